round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 35 +++
 rtl/round_robin_arbiter.sv | 176 +++++++++++++++++
 tb/tb_round_robin_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the four-agent round-robin arbiter.
//   NUM_REQ      number of requesting agents
//   agent_t      agent index (2 bits)
//   req_vec_t    one bit per agent
//   arb_state_e  arbiter FSM states
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned AGENT_W = 2;

    typedef logic [AGENT_W-1:0] agent_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // One-hot vector with only the bit of agent a set.
    function automatic req_vec_t agent_onehot(input agent_t a);
        req_vec_t v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin owner selection (purely combinational).
//   req        request vector, one bit per agent
//   last_owner most recently granted agent; search starts one past it
//   exclude    agents masked out of the search
//   valid_c    some non-excluded agent is requesting
//   pick_c     first requesting agent found, wrapping 3 -> 0
module rr_pick
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  agent_t   last_owner,
    input  req_vec_t exclude,
    output logic     valid_c,
    output agent_t   pick_c
);

    req_vec_t cand;
    agent_t   idx;

    // Offset NUM_REQ wraps back to last_owner itself, so it is searched last.
    always_comb begin
        cand    = req & ~exclude;
        valid_c = 1'b0;
        pick_c  = '0;
        idx     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = last_owner + AGENT_W'(i);
            if (!valid_c && cand[idx]) begin
                valid_c = 1'b1;
                pick_c  = idx;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Four-agent round-robin arbiter with registered one-hot grants.
// Optional hold-time preemption is enabled by defining ARB_TIMEOUT_EN.
//   clock, reset        clock; asynchronous active-high reset
//   req_0..req_3        agent requests
//   gnt_0..gnt_3        registered grants, one-hot or all zero
//   gnt_id              index of the current owner, 0 when idle
//   busy                high while any grant is high
//   expire              one-cycle pulse when an owner is preempted on timeout
module round_robin_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       req_3,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       gnt_3,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       expire
);

    // Reject illegal parameter combinations at elaboration.
    if (MAX_HOLD < 1 || MAX_HOLD > 255 || HOLD_W < 1 ||
        (HOLD_W < 9 && (1 << HOLD_W) <= MAX_HOLD)) begin : g_bad_params
        $error("round_robin_arbiter: illegal MAX_HOLD/HOLD_W");
    end

    req_vec_t   req_v;
    arb_state_e state_q, state_d;
    agent_t     owner_q, owner_d;
    agent_t     last_owner_q;
    req_vec_t   gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       new_grant_c;
    req_vec_t   excl_c;
    logic       pick_valid_c;
    agent_t     pick_c;
    logic       hold_reached_c;

    assign req_v = {req_3, req_2, req_1, req_0};

    // The current owner never wins its own handover or preemption search.
    assign excl_c = (state_q == OWNED) ? agent_onehot(owner_q) : '0;

    rr_pick u_pick (
        .req        (req_v),
        .last_owner (last_owner_q),
        .exclude    (excl_c),
        .valid_c    (pick_valid_c),
        .pick_c     (pick_c)
    );

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              preempt_c;
    logic              expire_q;

    // Counter is 0 in the first grant cycle, so the owner's MAX_HOLD-th
    // cycle is the one where the counter is about to reach MAX_HOLD.
    assign hold_reached_c = (hold_cnt_q >= HOLD_W'(MAX_HOLD - 1));
    assign preempt_c      = (state_q == OWNED) && req_v[owner_q] &&
                            hold_reached_c && pick_valid_c;

    // Hold counter: clear on new grant or idle, saturate at MAX_HOLD.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant_c || state_d == IDLE) begin
            hold_cnt_d = '0;
        end else if (state_q == OWNED && hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
            expire_q   <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            expire_q   <= preempt_c;
        end
    end

    assign expire = expire_q;
`else
    assign hold_reached_c = 1'b0;
    assign expire         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next owner.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        new_grant_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d     = OWNED;
                    owner_d     = pick_c;
                    new_grant_c = 1'b1;
                end
            end
            OWNED: begin
                if (!req_v[owner_q]) begin
                    // Release: hand over on the same edge or fall idle.
                    if (pick_valid_c) begin
                        owner_d     = pick_c;
                        new_grant_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else if (hold_reached_c && pick_valid_c) begin
                    owner_d     = pick_c;
                    new_grant_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    // Next registered outputs, derived from the next state.
    always_comb begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (state_d == OWNED) begin
            gnt_d  = agent_onehot(owner_d);
            busy_d = 1'b1;
        end
    end

    // Owner bookkeeping and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q      <= '0;
            last_owner_q <= agent_t'(NUM_REQ - 1);
            gnt_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            owner_q <= owner_d;
            if (new_grant_c) begin
                last_owner_q <= owner_d;
            end
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
        end
    end

    assign gnt_0  = gnt_q[0];
    assign gnt_1  = gnt_q[1];
    assign gnt_2  = gnt_q[2];
    assign gnt_3  = gnt_q[3];
    assign gnt_id = owner_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter; timeout scenarios run when
// ARB_TIMEOUT_EN is defined.
module tb_round_robin_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req_v;
    logic       gnt_0, gnt_1, gnt_2, gnt_3;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expire;

    int unsigned total;
    int unsigned bad;
    int unsigned order [5];
    int unsigned o;

    round_robin_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req_0  (req_v[0]),
        .req_1  (req_v[1]),
        .req_2  (req_v[2]),
        .req_3  (req_v[3]),
        .gnt_0  (gnt_0),
        .gnt_1  (gnt_1),
        .gnt_2  (gnt_2),
        .gnt_3  (gnt_3),
        .gnt_id (gnt_id),
        .busy   (busy),
        .expire (expire)
    );

    initial clock = 1'b1;
    always #2 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [1:0] id, input logic b, input logic e);
        logic [3:0] gv;
        gv = {gnt_3, gnt_2, gnt_1, gnt_0};
        total++;
        assert (gv === g) else begin
            bad++;
            $error("FAIL %s gnt: got %b want %b", tag, gv, g);
        end
        total++;
        assert (gnt_id === id) else begin
            bad++;
            $error("FAIL %s gnt_id: got %0d want %0d", tag, gnt_id, id);
        end
        total++;
        assert (busy === b) else begin
            bad++;
            $error("FAIL %s busy: got %b want %b", tag, busy, b);
        end
        total++;
        assert (expire === e) else begin
            bad++;
            $error("FAIL %s expire: got %b want %b", tag, expire, e);
        end
        total++;
        assert ($onehot0(gv)) else begin
            bad++;
            $error("FAIL %s onehot: got %b want at most one bit", tag, gv);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        order = '{0, 1, 2, 3, 0};
        req_v = 4'b0000;
        reset = 1'b1;

        // Reset state.
        #3;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        #7;
        reset = 1'b0;
        step();
        expect_out("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fairness: all request, each owner releases after 2 cycles.
        req_v = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            o = order[k];
            step();
            expect_out($sformatf("fair%0d_a", k), 4'(1 << o), 2'(o), 1'b1, 1'b0);
            if (k == 1) req_v[0] = 1'b1;
            step();
            expect_out($sformatf("fair%0d_b", k), 4'(1 << o), 2'(o), 1'b1, 1'b0);
            req_v[o] = 1'b0;
        end
        step();
        expect_out("fair_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester for 5 cycles.
        req_v = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_out($sformatf("single%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req_v = 4'b0000;
        step();
        expect_out("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotation: serve agent 2, then 1 and 3 together -> 3 first.
        req_v = 4'b0100;
        step();
        expect_out("rot_serve2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req_v = 4'b0000;
        step();
        expect_out("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_v = 4'b1010;
        step();
        expect_out("rot_gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        expect_out("rot_gnt3_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        req_v = 4'b0010;
        step();
        expect_out("rot_gnt1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req_v = 4'b0000;
        step();
        expect_out("rot_done", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset mid-grant drops the grant immediately.
        req_v = 4'b0010;
        step();
        expect_out("rst_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        expect_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_v = 4'b0110;
        #4;
        expect_out("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        #5;
        reset = 1'b0;
        step();
        expect_out("rst_first_gnt1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req_v = 4'b0100;
        step();
        expect_out("rst_handover2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req_v = 4'b0000;
        step();
        expect_out("rst_done", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Timeout: owner 0 preempted after 4 grant cycles by agent 2.
        req_v = 4'b0001;
        step();
        expect_out("to_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        req_v = 4'b0101;
        for (int k = 2; k <= 4; k++) begin
            step();
            expect_out($sformatf("to_c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step();
        expect_out("to_preempt", 4'b0100, 2'd2, 1'b1, 1'b1);
        step();
        expect_out("to_after", 4'b0100, 2'd2, 1'b1, 1'b0);
        req_v = 4'b0001;
        step();
        expect_out("to_back0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // No competitor: owner 0 keeps the grant well past MAX_HOLD.
        for (int k = 0; k < 20; k++) begin
            step();
            expect_out($sformatf("hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req_v = 4'b0000;
        step();
        expect_out("hold_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
